seg7_updown_counter: RTL and testbench

SEG7_UPDOWN_COUNTER -- requirements
Module: seg7_updown_counter

---
 rtl/seg7_updown_counter.sv | 151 +++++++++++++++
 tb/tb_seg7_updown_counter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_updown_counter.sv
// Multi-digit BCD/hex up/down counter with a scanned, active-low 7-segment display.
// Counting is paced by a prescaler tick; the display scan runs independently of counting.
module seg7_updown_counter #(
    parameter int CLK_HZ   = 100000000,
    parameter int TICK_HZ  = 1,
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000,
    parameter int DP_POS   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  hex_mode,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  dp_en,
    output logic [4*DIGITS-1:0]   count,
    output logic [7:0]            AN,
    output logic [6:0]            sseg,
    output logic                  DP,
    output logic                  led
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW       = $clog2(TICK_DIV);
    localparam int SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW       = 4 * DIGITS;

    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] count_q, count_d, stepped;
    logic          led_q, led_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]    scan_idx_q, scan_idx_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    sseg_q, sseg_d;
    logic          dp_q, dp_d;
    logic          tick, chain, scan_wrap;
    logic [3:0]    dig, dmax, cur_dig;

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    // Ripple one step through the digits; chain is the carry (up) or borrow (down).
    always_comb begin
        stepped = count_q;
        chain   = 1'b1;
        dmax    = hex_mode ? 4'hF : 4'h9;
        dig     = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = count_q[4*i +: 4];
            if (chain) begin
                if (up_dn) begin
                    if (dig == dmax || (!hex_mode && dig > 4'h9)) begin
                        dig = 4'h0;
                    end else begin
                        dig   = dig + 4'h1;
                        chain = 1'b0;
                    end
                end else begin
                    if (dig == 4'h0) begin
                        dig = dmax;
                    end else if (!hex_mode && dig > 4'h9) begin
                        dig   = 4'h9;
                        chain = 1'b0;
                    end else begin
                        dig   = dig - 4'h1;
                        chain = 1'b0;
                    end
                end
            end
            stepped[4*i +: 4] = dig;
        end
    end

    always_comb begin
        count_d = count_q;
        led_d   = led_q;
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (load) begin
            count_d = load_val;
            presc_d = '0;
        end else if (tick && en) begin
            count_d = stepped;
            if (chain) led_d = ~led_q;
        end
    end

    always_comb begin
        scan_wrap  = (scan_cnt_q == SW'(SCAN_DIV - 1));
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (scan_wrap) scan_idx_d = (scan_idx_q == 3'(DIGITS - 1)) ? 3'd0 : scan_idx_q + 3'd1;
    end

    // Display outputs are registered together so anode and segments switch on the same edge.
    always_comb begin
        cur_dig = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx_q == 3'(i)) cur_dig = count_q[4*i +: 4];
        end
        an_d             = 8'hFF;
        an_d[scan_idx_q] = 1'b0;
        dp_d             = !(dp_en && scan_idx_q == 3'(DP_POS));
        case (cur_dig)
            4'h0: sseg_d = 7'b1000000;
            4'h1: sseg_d = 7'b1111001;
            4'h2: sseg_d = 7'b0100100;
            4'h3: sseg_d = 7'b0110000;
            4'h4: sseg_d = 7'b0011001;
            4'h5: sseg_d = 7'b0010010;
            4'h6: sseg_d = 7'b0000010;
            4'h7: sseg_d = 7'b1111000;
            4'h8: sseg_d = 7'b0000000;
            4'h9: sseg_d = 7'b0010000;
            4'hA: sseg_d = 7'b0001000;
            4'hB: sseg_d = 7'b0000011;
            4'hC: sseg_d = 7'b1000110;
            4'hD: sseg_d = 7'b0100001;
            4'hE: sseg_d = 7'b0000110;
            default: sseg_d = 7'b0001110;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            count_q    <= '0;
            led_q      <= 1'b0;
            scan_cnt_q <= '0;
            scan_idx_q <= 3'd0;
            an_q       <= 8'hFF;
            sseg_q     <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            presc_q    <= presc_d;
            count_q    <= count_d;
            led_q      <= led_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            an_q       <= an_d;
            sseg_q     <= sseg_d;
            dp_q       <= dp_d;
        end
    end

    assign count = count_q;
    assign led   = led_q;
    assign AN    = an_q;
    assign sseg  = sseg_q;
    assign DP    = dp_q;

endmodule

// File: tb/tb_seg7_updown_counter.sv
// Directed and randomized checks of seg7_updown_counter against a cycle-level behavioural model.
module tb_seg7_updown_counter;
    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, up_dn = 1'b1, hex_mode = 1'b0, load = 1'b0, dp_en = 1'b0;
    logic [15:0] load_val = 16'h0;
    logic [15:0] count;
    logic [7:0]  AN;
    logic [6:0]  sseg;
    logic        DP, led;

    int checks = 0;
    int errors = 0;

    seg7_updown_counter #(.CLK_HZ(100), .TICK_HZ(10), .DIGITS(DIGITS), .SCAN_DIV(2), .DP_POS(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .hex_mode(hex_mode), .load(load),
        .load_val(load_val), .dp_en(dp_en), .count(count), .AN(AN), .sseg(sseg), .DP(DP), .led(led)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference state: counter value, cycles since last prescaler restart, edges since reset.
    logic [15:0] m_cnt;
    int          m_pre, m_cyc;
    logic        m_led;
    logic [7:0]  e_an;
    logic [6:0]  e_sseg;
    logic        e_dp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 16'h0; m_pre = 0; m_cyc = 0; m_led = 1'b0;
        e_an = 8'hFF; e_sseg = 7'h7F; e_dp = 1'b1;
    endtask

    // One counting step, derived directly from the digit rules.
    task automatic model_step();
        logic wrap;
        if (hex_mode) begin
            wrap  = up_dn ? (m_cnt == 16'hFFFF) : (m_cnt == 16'h0000);
            m_cnt = up_dn ? m_cnt + 16'h1 : m_cnt - 16'h1;
        end else begin
            int d[4];
            wrap = 1'b1;
            for (int i = 0; i < 4; i++) d[i] = int'((m_cnt >> (4*i)) & 16'hF);
            for (int i = 0; i < 4 && wrap; i++) begin
                if (up_dn) begin
                    if (d[i] >= 9) d[i] = 0;
                    else begin d[i]++; wrap = 1'b0; end
                end else begin
                    if (d[i] == 0) d[i] = 9;
                    else if (d[i] > 9) begin d[i] = 9; wrap = 1'b0; end
                    else begin d[i]--; wrap = 1'b0; end
                end
            end
            m_cnt = 16'(d[0] + (d[1] << 4) + (d[2] << 8) + (d[3] << 12));
        end
        if (wrap) m_led = ~m_led;
    endtask

    task automatic model_edge();
        int idx;
        idx    = (m_cyc / 2) % DIGITS;
        e_an   = 8'hFF & ~(8'h01 << idx);
        e_sseg = SEG_TAB[(m_cnt >> (4*idx)) & 16'hF];
        e_dp   = !(dp_en && idx == 1);
        if (load) begin
            m_cnt = load_val;
            m_pre = 0;
        end else if (m_pre == 9) begin
            if (en) model_step();
            m_pre = 0;
        end else begin
            m_pre++;
        end
        m_cyc++;
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("count", 32'(count), 32'(m_cnt));
            chk("led", 32'(led), 32'(m_led));
            chk("AN", 32'(AN), 32'(e_an));
            chk("sseg", 32'(sseg), 32'(e_sseg));
            chk("DP", 32'(DP), 32'(e_dp));
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; load_val = v;
        step();
        load = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"}, 32'(count), 32'h0);
        chk({tag, "_led"}, 32'(led), 32'h0);
        chk({tag, "_AN"}, 32'(AN), 32'hFF);
        chk({tag, "_sseg"}, 32'(sseg), 32'h7F);
        chk({tag, "_DP"}, 32'(DP), 32'h1);
    endtask

    logic [7:0] an_tab [4] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
    logic [6:0] sg_tab [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

    initial begin
        logic [7:0] prev_an;
        logic       found;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        en = 1'b1; up_dn = 1'b1; hex_mode = 1'b0;
        do_load(16'h0999); step(10); chk("bcd_up_carry", 32'(count), 32'h1000);
        do_load(16'h9999); step(10); chk("bcd_up_wrap", 32'(count), 32'h0000);
        chk("bcd_up_wrap_led", 32'(led), 32'h1);

        up_dn = 1'b0;
        do_load(16'h1000); step(10); chk("bcd_dn_borrow", 32'(count), 32'h0999);
        do_load(16'h0000); step(10); chk("bcd_dn_wrap", 32'(count), 32'h9999);
        chk("bcd_dn_wrap_led", 32'(led), 32'h0);

        hex_mode = 1'b1; up_dn = 1'b1;
        do_load(16'h00FF); step(10); chk("hex_up_carry", 32'(count), 32'h0100);
        do_load(16'hFFFF); step(10); chk("hex_up_wrap", 32'(count), 32'h0000);
        chk("hex_up_wrap_led", 32'(led), 32'h1);

        hex_mode = 1'b0; up_dn = 1'b0;
        do_load(16'h000C); step(10); chk("bcd_dn_invalid", 32'(count), 32'h0009);

        up_dn = 1'b1;
        do_load(16'h0005); step(9);
        do_load(16'h0050); chk("load_over_tick", 32'(count), 32'h0050);
        step(9); chk("no_early_step", 32'(count), 32'h0050);
        step(1); chk("step_after_load", 32'(count), 32'h0051);
        en = 1'b0; step(30); chk("en_hold", 32'(count), 32'h0051);

        dp_en = 1'b1;
        do_load(16'h1234);
        found = 1'b0; prev_an = AN;
        for (int k = 0; k < 12 && !found; k++) begin
            step();
            if (AN == 8'hFE && prev_an != 8'hFE) found = 1'b1;
            prev_an = AN;
        end
        chk("scan_align", 32'(found), 32'h1);
        for (int k = 0; k < 8; k++) begin
            chk("scan_AN", 32'(AN), 32'(an_tab[k/2]));
            chk("scan_sseg", 32'(sseg), 32'(sg_tab[k/2]));
            chk("scan_DP", 32'(DP), (k/2 == 1) ? 32'h0 : 32'h1);
            step();
        end

        do_load(16'h0042); step(3);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async_reset");
        model_reset();
        #2 rst_n = 1'b1;
        en = 1'b1; up_dn = 1'b1; hex_mode = 1'b0;
        step(9); chk("post_reset_no_tick", 32'(count), 32'h0000);
        step(1); chk("post_reset_first_tick", 32'(count), 32'h0001);

        for (int k = 0; k < 1500; k++) begin
            en    = ($urandom_range(0, 9) != 0);
            dp_en = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 29) == 0) up_dn    = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 29) == 0) hex_mode = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 4))
                    0: load_val = 16'h9999;
                    1: load_val = 16'hFFFF;
                    2: load_val = 16'h0000;
                    3: load_val = 16'h0999;
                    default: load_val = 16'($urandom);
                endcase
                load = 1'b1;
            end
            step();
            load = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
